// File: rtl/cpu_step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_step_defs
// Shared definitions for the run/single-step controller. The display logic
// decodes the same state codes to show RUN / HALT / STOP.
//   STATE_W : width of the state code driven on cpu_step_ctrl.state
//   state_t : HALT=0, RUN=1, STOP=2 (code 3 is illegal)
// -----------------------------------------------------------------------------
package cpu_step_defs;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw, bouncy push-button into the clk domain, debounces it
// and emits a registered one-cycle pulse on each accepted press.
// Ports:
//   clk    in  : system clock
//   clr_n  in  : asynchronous active-low reset
//   btn    in  : raw button level (1 = pressed), asynchronous
//   step_p out : one-cycle pulse on the 0->1 edge of the debounced level
// Parameter:
//   DEBOUNCE_CYCLES : consecutive cycles the synchronised level must differ
//                     from the debounced level before it is accepted
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn,
    output logic step_p
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          db_lvl;
    logic          db_lvl_d;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            db_lvl     <= 1'b0;
            db_lvl_d   <= 1'b0;
            stable_cnt <= '0;
            step_p     <= 1'b0;
        end else begin
            // synchroniser stage boundary
            sync_p0 <= btn;
            sync_p1 <= sync_p0;

            // debounce stage boundary: the count only advances while the
            // synchronised level disagrees; any agreement restarts it
            if (sync_p1 != db_lvl) begin
                if (stable_cnt == DB_LAST) begin
                    db_lvl     <= sync_p1;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end

            // edge stage boundary: pulse is registered, one cycle after the
            // debounced level rises
            db_lvl_d <= db_lvl;
            step_p   <= db_lvl & ~db_lvl_d;
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
// Run/single-step controller. Produces one-cycle CPU advance enables: one per
// rising edge of the divided clock in RUN, one per debounced step press in
// HALT, none once the CPU has executed HALT (STOP).
// Ports:
//   clk        in         : system clock (same as the frequency divider)
//   clr_n      in         : asynchronous active-low reset
//   slow_clk   in         : divided clock level, generated in the clk domain
//   run_sw     in         : raw run/halt switch (1 = run), asynchronous
//   step_btn   in         : raw step button (1 = pressed), asynchronous
//   cpu_halt   in         : CPU has executed HALT, clk-domain level
//   cpu_en     out        : registered one-cycle advance enable
//   state      out [2]    : current controller state (cpu_step_defs codes)
//   step_count out [CNT_W]: number of cpu_en pulses, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module cpu_step_ctrl
    import cpu_step_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               slow_clk,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               cpu_halt,
    output logic               cpu_en,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   step_count
);

    logic   slow_d;
    logic   tick;
    logic   run_p0;
    logic   run_s;
    logic   step_p;
    state_t st;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .clr_n  (clr_n),
        .btn    (step_btn),
        .step_p (step_p)
    );

    // slow_clk already lives in the clk domain, so a single delay flop is
    // enough to find its rising edges
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            slow_d <= 1'b0;
            run_p0 <= 1'b0;
            run_s  <= 1'b0;
        end else begin
            slow_d <= slow_clk;
            run_p0 <= run_sw;
            run_s  <= run_p0;
        end
    end

    assign tick = slow_clk & ~slow_d;

    // FSM stage boundary: cpu_en is registered and defaults low every cycle,
    // and neither tick nor step_p can be high on consecutive cycles, so
    // enables are always isolated single-cycle pulses
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st     <= ST_HALT;
            cpu_en <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            case (st)
                ST_HALT: begin
                    // run_s outranks step_p so a press racing the switch is dropped
                    if (cpu_halt)    st     <= ST_STOP;
                    else if (run_s)  st     <= ST_RUN;
                    else if (step_p) cpu_en <= 1'b1;
                end
                ST_RUN: begin
                    if (cpu_halt)    st     <= ST_STOP;
                    else if (!run_s) st     <= ST_HALT;
                    else if (tick)   cpu_en <= 1'b1;
                end
                ST_STOP: begin
                    if (!run_s && !cpu_halt) st <= ST_HALT;
                end
                default: st <= ST_HALT;
            endcase
        end
    end

    assign state = st;

    // counter stage boundary: reflects each pulse one cycle after it rises
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)      step_count <= '0;
        else if (cpu_en) step_count <= step_count + 1'b1;
    end

endmodule
